// File: rtl/wave_capture.sv
// -----------------------------------------------------------------------------
// wave_capture
//
// Purpose:
//   Captures one triggered window of audio into a double-buffered sample RAM
//   for a waveform display. The block waits for a positive zero crossing
//   (negative sample followed by a non-negative one). It then writes 256
//   offset-binary bytes into the RAM half that the display is not reading.
//   When the buffer is full, it waits for the display to go idle, swaps the
//   halves and re-arms.
//
// Ports:
//   clk                i   1   system clock, rising edge
//   reset              i   1   asynchronous, active-low reset
//   new_sample_ready   i   1   strobe: new_sample_in is valid this cycle
//   new_sample_in      i  16   two's-complement audio sample
//   wave_display_idle  i   1   high while the display is not scanning the wave
//   write_address      o   9   sample RAM write address {half, index}
//   write_enable       o   1   sample RAM write strobe (one cycle per write)
//   write_sample       o   8   offset-binary sample byte
//   read_index         o   1   RAM half currently owned by the display
//
// Configuration:
//   WAVE_CAPTURE_DECIMATE_EN  when defined, only the 1st, 3rd, 5th, ...
//                             accepted sample of a capture is written, so one
//                             buffer spans 512 input samples.
// -----------------------------------------------------------------------------
module wave_capture (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_sample_ready,
  input  logic [15:0] new_sample_in,
  input  logic        wave_display_idle,
  output logic [8:0]  write_address,
  output logic        write_enable,
  output logic [7:0]  write_sample,
  output logic        read_index
);

  localparam logic [1:0] ST_ARMED  = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  logic [1:0]  r_state;
  logic [7:0]  r_count;
  logic [15:0] r_prev_sample;
  logic        r_idle_q;
  logic        r_read_index;
  logic        r_write_enable;
  logic [8:0]  r_write_address;
  logic [7:0]  r_write_sample;

  logic        w_crossing;
  logic        w_idle_rise;
  logic        w_keep;
  logic        w_write;

  // Positive zero crossing: previous sample negative, current one not.
  assign w_crossing  = new_sample_ready & r_prev_sample[15] & ~new_sample_in[15];
  assign w_idle_rise = wave_display_idle & ~r_idle_q;

`ifdef WAVE_CAPTURE_DECIMATE_EN
  // r_skip is low for the 1st, 3rd, 5th ... accepted sample of a capture.
  logic r_skip;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_skip <= 1'b0;
    end else if (r_state == ST_ARMED) begin
      r_skip <= 1'b0;
    end else if ((r_state == ST_ACTIVE) && new_sample_ready) begin
      r_skip <= ~r_skip;
    end
  end

  assign w_keep = ~r_skip;
`else
  assign w_keep = 1'b1;
`endif

  assign w_write = (r_state == ST_ACTIVE) & new_sample_ready & w_keep;

  // NOTE: every register below is updated with non-blocking assignments, so
  // all right-hand sides see the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_ARMED;
      r_count         <= 8'd0;
      r_prev_sample   <= 16'd0;
      r_idle_q        <= 1'b0;
      r_read_index    <= 1'b0;
      r_write_enable  <= 1'b0;
      r_write_address <= 9'd0;
      r_write_sample  <= 8'd0;
    end else begin
      r_write_enable <= w_write;
      r_idle_q       <= wave_display_idle;

      if (new_sample_ready) begin
        r_prev_sample <= new_sample_in;
      end

      // Address and data only move on a write and hold otherwise.
      if (w_write) begin
        r_write_address <= {~r_read_index, r_count};
        r_write_sample  <= {~new_sample_in[15], new_sample_in[14:8]};
        r_count         <= r_count + 8'd1;
      end

      case (r_state)
        ST_ARMED: begin
          // A crossing wins over anything else; the crossing sample itself
          // is not stored.
          if (w_crossing) begin
            r_state <= ST_ACTIVE;
            r_count <= 8'd0;
          end
        end
        ST_ACTIVE: begin
          // The 256th write fills the buffer; the count wraps to zero but no
          // further write happens because the state leaves ACTIVE.
          if (w_write && (r_count == 8'd255)) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_idle_rise) begin
            r_read_index <= ~r_read_index;
            r_state      <= ST_ARMED;
          end
        end
        default: begin
          r_state <= ST_ARMED;
        end
      endcase
    end
  end

  assign write_address = r_write_address;
  assign write_enable  = r_write_enable;
  assign write_sample  = r_write_sample;
  assign read_index    = r_read_index;

endmodule

// File: tb/tb_wave_capture.sv
// -----------------------------------------------------------------------------
// tb_wave_capture
//
// Self-checking bench for wave_capture. A behavioural model tracks how many
// bytes of the current buffer have been filled (-1 = waiting for a trigger,
// 256 = full), which RAM half the display owns, and the expected RAM write
// per clock edge. Directed scenarios are mixed with $urandom stimulus. The
// same bench works with and without WAVE_CAPTURE_DECIMATE_EN.
// -----------------------------------------------------------------------------
module tb_wave_capture;

  logic        clk;
  logic        reset;
  logic        new_sample_ready;
  logic [15:0] new_sample_in;
  logic        wave_display_idle;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;

  wave_capture dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef WAVE_CAPTURE_DECIMATE_EN
  localparam int DECIM = 2;
`else
  localparam int DECIM = 1;
`endif

  int checks = 0;
  int errors = 0;
  int n_writes = 0;

  // Reference model state.
  int          m_fill;
  int          m_taken;
  logic [15:0] m_prev;
  logic        m_idle_q;
  logic        m_bank;
  logic        exp_we;
  logic [8:0]  exp_addr;
  logic [7:0]  exp_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_fill   = -1;
    m_taken  = 0;
    m_prev   = 16'd0;
    m_idle_q = 1'b0;
    m_bank   = 1'b0;
    exp_we   = 1'b0;
    exp_addr = 9'd0;
    exp_data = 8'd0;
  endtask

  // Expected effect of one rising clock edge with the given inputs.
  task automatic model_edge(input logic rdy, input logic [15:0] s, input logic idle);
    int  biased;
    bit  keep;
    exp_we = 1'b0;
    if (m_fill < 0) begin
      if (rdy && $signed(m_prev) < 0 && $signed(s) >= 0) begin
        m_fill  = 0;
        m_taken = 0;
      end
    end else if (m_fill < 256) begin
      if (rdy) begin
        keep = ((m_taken % DECIM) == 0);
        m_taken++;
        if (keep) begin
          biased   = int'($signed(s)) + 32768;
          exp_we   = 1'b1;
          exp_addr = 9'((m_bank ? 0 : 256) + m_fill);
          exp_data = 8'(biased / 256);
          m_fill++;
        end
      end
    end else begin
      if (idle && !m_idle_q) begin
        m_bank = ~m_bank;
        m_fill = -1;
      end
    end
    if (rdy) m_prev = s;
    m_idle_q = idle;
  endtask

  task automatic compare_outputs();
    check("write_enable", 32'(write_enable), 32'(exp_we));
    check("read_index", 32'(read_index), 32'(m_bank));
    check("write_address", 32'(write_address), 32'(exp_addr));
    check("write_sample", 32'(write_sample), 32'(exp_data));
  endtask

  // One clock: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic step(input logic rdy, input logic [15:0] s, input logic idle);
    @(negedge clk);
    new_sample_ready  = rdy;
    new_sample_in     = s;
    wave_display_idle = idle;
    @(posedge clk);
    model_edge(rdy, s, idle);
    #1;
    compare_outputs();
    if (write_enable) n_writes++;
  endtask

  initial begin
    int n_cap;
    int w0;
    logic idle;

    reset             = 1'b0;
    new_sample_ready  = 1'b0;
    new_sample_in     = 16'd0;
    wave_display_idle = 1'b0;
    model_reset();

    // Reset state.
    #12;
    compare_outputs();
    @(negedge clk);
    reset = 1'b1;

    // Positive samples without a crossing: nothing written.
    step(1'b1, 16'h0100, 1'b0);
    step(1'b1, 16'h7FFF, 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    step(1'b0, 16'h0000, 1'b0);
    check("armed_no_write", 32'(n_writes), 32'd0);

    // Crossing then first sample.
    step(1'b1, 16'hFF00, 1'b0);
    step(1'b1, 16'h0200, 1'b0);
    check("crossing_not_written", 32'(write_enable), 32'd0);
    step(1'b1, 16'h1234, 1'b0);
    check("first_we", 32'(write_enable), 32'd1);
    check("first_addr", 32'(write_address), 32'h100);
    check("first_data", 32'(write_sample), 32'h92);
    step(1'b0, 16'h0000, 1'b0);
    check("we_one_cycle", 32'(write_enable), 32'd0);
    check("addr_hold", 32'(write_address), 32'h100);

    // Fill the rest of the buffer with random samples and random gaps.
    n_cap = 1;
    for (int i = 1; i < 256 * DECIM; i++) begin
      if (($urandom % 4) == 0) step(1'b0, 16'($urandom), 1'b0);
      step(1'b1, 16'($urandom), 1'b0);
      if (write_enable) begin
        check("seq_addr", 32'(write_address), 32'(9'h100 + 9'(n_cap)));
        n_cap++;
      end
    end
    check("capture_count", 32'(n_cap), 32'd256);
    step(1'b1, 16'h8001, 1'b0);
    check("no_257th_write", 32'(write_enable), 32'd0);
    step(1'b1, 16'h0001, 1'b0);
    check("wait_ignores_crossing", 32'(write_enable), 32'd0);

    // Display idle edge swaps halves.
    step(1'b0, 16'h0000, 1'b1);
    check("read_index_toggled", 32'(read_index), 32'd1);
    step(1'b0, 16'h0000, 1'b0);
    step(1'b1, 16'hF000, 1'b1);
    step(1'b1, 16'h0100, 1'b0);
    step(1'b1, 16'h8000, 1'b0);
    check("bank0_we", 32'(write_enable), 32'd1);
    check("bank0_addr", 32'(write_address), 32'h000);
    check("bank0_data", 32'(write_sample), 32'h00);

    // 99 more writes, then reset mid-capture.
    w0 = n_writes;
    for (int i = 0; i < 99 * DECIM; i++) step(1'b1, 16'($urandom), 1'($urandom % 2));
    check("writes_before_reset", 32'(n_writes - w0 + 1), 32'd100);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check("rst_we", 32'(write_enable), 32'd0);
    check("rst_addr", 32'(write_address), 32'd0);
    check("rst_data", 32'(write_sample), 32'd0);
    check("rst_read_index", 32'(read_index), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    w0 = n_writes;
    for (int i = 0; i < 50; i++) step(1'b1, 16'($urandom) & 16'h7FFF, 1'b0);
    check("no_write_after_reset", 32'(n_writes - w0), 32'd0);

    // Random soak against the model.
    idle = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (($urandom % 20) == 0) idle = ~idle;
      step(1'(($urandom % 3) != 0), 16'($urandom), idle);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wave_capture.md
WAVE_CAPTURE -- requirements
Module: wave_capture

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset. Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
REQ-002 The block SHALL have the following data and control ports:
- new_sample_ready  input  1  one-cycle strobe; new_sample_in is valid this cycle.
- new_sample_in  input  16  two's-complement audio sample.
- wave_display_idle  input  1  high while the downstream display stage is not scanning the waveform region.
- write_address  output  9  sample RAM write address.
- write_enable  output  1  sample RAM write strobe.
- write_sample  output  8  offset-binary sample written to RAM.
- read_index  output  1  RAM half the display reads; the capture stage writes the other half.

Function
REQ-003 States SHALL be ARMED, ACTIVE and WAIT.
REQ-004 prev_sample (16 b) SHALL load new_sample_in on every cycle with new_sample_ready=1, in every state.
REQ-005 ARMED: a positive zero crossing SHALL be prev_sample[15]=1 and new_sample_in[15]=0 with new_sample_ready=1.
- On a crossing: go to ACTIVE and clear count (8 b).
- The crossing sample itself SHALL NOT be written.
REQ-006 ACTIVE: each accepted sample SHALL produce one RAM write.
- The write SHALL appear on the outputs the cycle after the accepting edge.
- write_address = {~read_index, count}.
- write_sample = {~s[15], s[14:8]}.
- count increments by 1 after each write.
REQ-007 ACTIVE SHALL exit to WAIT on the 256th write (count = 255), with no wrap into a 257th write.
REQ-008 write_enable SHALL be high for exactly one cycle per accepted sample in ACTIVE, and low otherwise.
- write_address and write_sample SHALL hold their last values while write_enable is low.
REQ-009 WAIT: samples SHALL be ignored for writing but still update prev_sample.
- On a rising edge of wave_display_idle (registered previous value 0, current value 1): toggle read_index and go to ARMED.
REQ-010 A wave_display_idle rising edge outside WAIT SHALL have no effect, and read_index SHALL change only per REQ-009.
REQ-011 new_sample_ready held high on consecutive cycles SHALL be treated as one sample per cycle.
REQ-012 In ARMED, a crossing and an idle edge in the same cycle SHALL take the crossing only.

Reset
REQ-013 While reset=0 the block SHALL be forced to:
- state = ARMED; count, prev_sample and the idle edge register = 0.
- read_index = 0; write_enable = 0; write_address = 0; write_sample = 0.
REQ-014 Reset asserted mid-capture SHALL abandon the partial buffer, and no further write SHALL occur until the next crossing after release.

Configuration
REQ-015 The macro WAVE_CAPTURE_DECIMATE_EN SHALL control decimation.
- When defined: in ACTIVE only every second accepted sample (1st, 3rd, 5th, ...) is written, so one capture spans 512 input samples.
- When undefined: every accepted sample is written (REQ-006).
- Trigger detection and all other behaviour SHALL be identical in both builds.

Verification
REQ-016 The bench SHALL cover the following scenarios (macro undefined unless stated):
- Reset release, then strobe samples 0x0100, 0x7FFF -> no write_enable, read_index=0, state ARMED.
- Samples 0xFF00 then 0x0200 (crossing), then 0x1234 -> one write: write_address=0x100, write_sample=0x92, one cycle after the 0x1234 strobe.
- Crossing, then 256 strobes -> exactly 256 writes at addresses 0x100..0x1FF; the 257th strobe produces no write.
- WAIT with wave_display_idle pulsed 0->1 -> read_index=1. Next crossing plus sample 0x8000 -> write_address=0x000, write_sample=0x00.
- Reset driven low after 100 writes -> outputs zero immediately. After release with no crossing, 50 strobes -> no writes.
- WAVE_CAPTURE_DECIMATE_EN defined: crossing, then 512 strobes -> 256 writes, all taken from odd-numbered samples.
